// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - handshake and data bundle between IF, decode_stage and EX
// Purpose: groups the decode_stage upstream, write-back, hazard and downstream signals.
// Ports (signals):
//   upstream  : i_valid, o_ready, i_instr, i_pc, i_flush
//   write-back: i_wr, i_wr_rd, i_write_data
//   hazard    : i_ex_load, i_ex_rd
//   downstream: o_valid, i_ready, o_rs1_data, o_rs2_data, o_imm_data, o_opcode,
//               o_func3, o_alu_ctrl, o_rs1, o_rs2, o_rd, o_pc, o_illegal
// Modports: master drives the i_* signals, slave (the decode stage) drives the o_* signals.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic            i_flush;
  logic            i_wr;
  logic [4:0]      i_wr_rd;
  logic [XLEN-1:0] i_write_data;
  logic            i_ex_load;
  logic [4:0]      i_ex_rd;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic [XLEN-1:0] o_imm_data;
  logic [6:0]      o_opcode;
  logic [2:0]      o_func3;
  logic [3:0]      o_alu_ctrl;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic [4:0]      o_rd;
  logic [XLEN-1:0] o_pc;
  logic            o_illegal;

  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_wr, i_wr_rd, i_write_data,
           i_ex_load, i_ex_rd, i_ready,
    input  o_ready, o_valid, o_rs1_data, o_rs2_data, o_imm_data, o_opcode,
           o_func3, o_alu_ctrl, o_rs1, o_rs2, o_rd, o_pc, o_illegal
  );

  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_wr, i_wr_rd, i_write_data,
           i_ex_load, i_ex_rd, i_ready,
    output o_ready, o_valid, o_rs1_data, o_rs2_data, o_imm_data, o_opcode,
           o_func3, o_alu_ctrl, o_rs1, o_rs2, o_rd, o_pc, o_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32 decode stage with register file, bypass and hazard stall
// Purpose: decodes one instruction per cycle into operands, immediate and ALU control,
//   holding the result in an output register with valid/ready handshaking.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (clears output register and register file)
//   bus  - decode_stage_if.slave: upstream instr/pc/valid/ready/flush, write-back port,
//          EX load hazard info, downstream decoded fields with valid/ready
// Parameters: XLEN datapath width, REG_COUNT 32 or 16, WB_BYPASS forwards same-cycle WB data.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int WB_BYPASS = 1
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam int         IW        = $clog2(REG_COUNT);
  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [XLEN-1:0] regs [REG_COUNT];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [4:0]  rs1, rs2, rd;
  logic        legal, rs1_used, rs2_used, rd_used, illegal;
  logic [31:0] imm32;
  logic [3:0]  alu;
  logic [XLEN-1:0] rs1_raw, rs2_raw, rs1_val, rs2_val;
  logic        we, stall, advance, accept;

  assign instr  = bus.i_instr;
  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // alt selects SUB/SRA; the caller decides whether instr[30] may act as alt.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_of = ALU_SLL;
      3'd2:    alu_of = ALU_SLT;
      3'd3:    alu_of = ALU_SLTU;
      3'd4:    alu_of = ALU_XOR;
      3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  always_comb begin
    legal    = 1'b1;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    rd_used  = 1'b1;
    imm32    = '0;
    alu      = ALU_ADD;
    case (opcode)
      OP_LUI: begin
        rs1_used = 1'b0;
        imm32    = {instr[31:12], 12'b0};
        alu      = ALU_PASSB;
      end
      OP_AUIPC: begin
        rs1_used = 1'b0;
        imm32    = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        rs1_used = 1'b0;
        imm32    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_FENCE, OP_SYSTEM: imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_OPIMM: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        // Only shifts honour instr[30]; for ADDI it is just an immediate bit.
        alu   = alu_of(func3, (func3 == 3'd5) && instr[30]);
      end
      OP_OP: begin
        rs2_used = 1'b1;
        alu      = alu_of(func3, instr[30]);
      end
      OP_STORE: begin
        rs2_used = 1'b1;
        rd_used  = 1'b0;
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        rs2_used = 1'b1;
        rd_used  = 1'b0;
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (func3[2:1])
          2'b10:   alu = ALU_SLT;
          2'b11:   alu = ALU_SLTU;
          default: alu = ALU_SUB;
        endcase
      end
      default: begin
        legal   = 1'b0;
        rd_used = 1'b0;
      end
    endcase
  end

  assign illegal = !legal
                || (rs1_used && ({1'b0, rs1} >= REG_LIMIT))
                || (rs2_used && ({1'b0, rs2} >= REG_LIMIT))
                || (rd_used  && ({1'b0, rd}  >= REG_LIMIT));

  // x0 and out-of-range indices read as zero; bypass never applies to x0.
  always_comb begin
    rs1_raw = '0;
    if (rs1 != 5'd0 && ({1'b0, rs1} < REG_LIMIT)) begin
      if (WB_BYPASS != 0 && bus.i_wr && bus.i_wr_rd == rs1) rs1_raw = bus.i_write_data;
      else rs1_raw = regs[rs1[IW-1:0]];
    end
  end

  always_comb begin
    rs2_raw = '0;
    if (rs2 != 5'd0 && ({1'b0, rs2} < REG_LIMIT)) begin
      if (WB_BYPASS != 0 && bus.i_wr && bus.i_wr_rd == rs2) rs2_raw = bus.i_write_data;
      else rs2_raw = regs[rs2[IW-1:0]];
    end
  end

  assign rs1_val = rs1_used ? rs1_raw : '0;
  assign rs2_val = rs2_used ? rs2_raw : '0;

  assign we = bus.i_wr && (bus.i_wr_rd != 5'd0) && ({1'b0, bus.i_wr_rd} < REG_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[bus.i_wr_rd[IW-1:0]] <= bus.i_write_data;
    end
  end

  // Load-use hazard only matters for operands the instruction actually reads.
  assign stall   = bus.i_valid && bus.i_ex_load && (bus.i_ex_rd != 5'd0)
                && ((rs1_used && bus.i_ex_rd == rs1) || (rs2_used && bus.i_ex_rd == rs2));
  assign advance = !bus.o_valid || bus.i_ready;
  assign bus.o_ready = advance && !stall && !bus.i_flush;
  assign accept  = bus.i_valid && bus.o_ready;

  // Flush empties the output register even under backpressure; accept is
  // already false whenever flush is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid    <= 1'b0;
      bus.o_illegal  <= 1'b0;
      bus.o_rs1_data <= '0;
      bus.o_rs2_data <= '0;
      bus.o_imm_data <= '0;
      bus.o_opcode   <= '0;
      bus.o_func3    <= '0;
      bus.o_alu_ctrl <= '0;
      bus.o_rs1      <= '0;
      bus.o_rs2      <= '0;
      bus.o_rd       <= '0;
      bus.o_pc       <= '0;
    end else if (advance || bus.i_flush) begin
      bus.o_valid <= accept;
      if (accept) begin
        bus.o_illegal  <= illegal;
        bus.o_rs1_data <= rs1_val;
        bus.o_rs2_data <= rs2_val;
        bus.o_imm_data <= XLEN'($signed(imm32));
        bus.o_opcode   <= opcode;
        bus.o_func3    <= func3;
        bus.o_alu_ctrl <= illegal ? ALU_ADD : alu;
        bus.o_rs1      <= rs1;
        bus.o_rs2      <= rs2;
        bus.o_rd       <= rd;
        bus.o_pc       <= bus.i_pc;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (bypass, no-bypass and RV32E instances)
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_flush, i_wr, i_ex_load, i_ready;
  logic [31:0] i_instr, i_pc, i_write_data;
  logic [4:0]  i_wr_rd, i_ex_rd;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) b0 ();
  decode_stage_if #(.XLEN(32)) b1 ();
  decode_stage_if #(.XLEN(32)) b2 ();

  assign b0.i_valid = i_valid;  assign b1.i_valid = i_valid;  assign b2.i_valid = i_valid;
  assign b0.i_instr = i_instr;  assign b1.i_instr = i_instr;  assign b2.i_instr = i_instr;
  assign b0.i_pc = i_pc;        assign b1.i_pc = i_pc;        assign b2.i_pc = i_pc;
  assign b0.i_flush = i_flush;  assign b1.i_flush = i_flush;  assign b2.i_flush = i_flush;
  assign b0.i_wr = i_wr;        assign b1.i_wr = i_wr;        assign b2.i_wr = i_wr;
  assign b0.i_wr_rd = i_wr_rd;  assign b1.i_wr_rd = i_wr_rd;  assign b2.i_wr_rd = i_wr_rd;
  assign b0.i_write_data = i_write_data;
  assign b1.i_write_data = i_write_data;
  assign b2.i_write_data = i_write_data;
  assign b0.i_ex_load = i_ex_load; assign b1.i_ex_load = i_ex_load; assign b2.i_ex_load = i_ex_load;
  assign b0.i_ex_rd = i_ex_rd;  assign b1.i_ex_rd = i_ex_rd;  assign b2.i_ex_rd = i_ex_rd;
  assign b0.i_ready = i_ready;  assign b1.i_ready = i_ready;  assign b2.i_ready = i_ready;

  decode_stage #(.XLEN(32), .REG_COUNT(32), .WB_BYPASS(1)) u_byp  (.clk(clk), .rst(rst), .bus(b0));
  decode_stage #(.XLEN(32), .REG_COUNT(32), .WB_BYPASS(0)) u_nbyp (.clk(clk), .rst(rst), .bus(b1));
  decode_stage #(.XLEN(32), .REG_COUNT(16), .WB_BYPASS(1)) u_e    (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic [31:0] instr;
    logic        wr;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic [31:0] e_rs1;
    logic [31:0] e_rs1_nb;
    logic [31:0] e_rs2;
    logic [31:0] e_imm;
    logic [3:0]  e_alu;
    logic [4:0]  e_rd;
    logic        e_ill;
    logic        e_ill16;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    i_valid = 0; i_flush = 0; i_wr = 0; i_ex_load = 0; i_ready = 1;
    i_wr_rd = 0; i_ex_rd = 0; i_write_data = 0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    i_wr = 1; i_wr_rd = r; i_write_data = d;
    step();
    i_wr = 0;
  endtask

  task automatic issue(input logic [31:0] ins);
    i_valid = 1; i_instr = ins; i_ready = 1;
    step();
    i_valid = 0;
  endtask

  initial begin
    //          instr          wr  rd  wdata          rs1           rs1_nb        rs2           imm           alu   rd     ill  ill16
    vecs[0]  = '{32'h00028333, 0, 0,  32'h0,        32'h1234,     32'h1234,     32'h0,        32'h0,        4'd0, 5'd6,  0, 0};
    vecs[1]  = '{32'hFFF38413, 1, 7,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        32'hFFFFFFFF, 4'd0, 5'd8,  0, 0};
    vecs[2]  = '{32'h405384B3, 0, 0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h1234,     32'h0,        4'd1, 5'd9,  0, 0};
    vecs[3]  = '{32'h000012B7, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h1000,     4'd10,5'd5,  0, 0};
    vecs[4]  = '{32'h0053A423, 0, 0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h1234,     32'h8,        4'd0, 5'd8,  0, 0};
    vecs[5]  = '{32'hFE728EE3, 0, 0,  32'h0,        32'h1234,     32'h1234,     32'hDEADBEEF, 32'hFFFFFFFC, 4'd1, 5'd29, 0, 0};
    vecs[6]  = '{32'h008000EF, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h8,        4'd0, 5'd1,  0, 0};
    vecs[7]  = '{32'h0000000B, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        4'd0, 5'd0,  1, 1};
    vecs[8]  = '{32'h002088B3, 0, 0,  32'h0,        32'h11,       32'h11,       32'h22,       32'h0,        4'd0, 5'd17, 0, 1};
    vecs[9]  = '{32'h4042D513, 0, 0,  32'h0,        32'h1234,     32'h1234,     32'h0,        32'h404,      4'd7, 5'd10, 0, 0};
    vecs[10] = '{32'h000005B3, 1, 0,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h0,        4'd0, 5'd11, 0, 0};
    vecs[11] = '{32'h00000633, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        4'd0, 5'd12, 0, 0};

    idle();
    i_instr = 0; i_pc = 0;
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    chk("reset o_valid", 32'(b0.o_valid), 0);
    chk("reset o_illegal", 32'(b0.o_illegal), 0);
    chk("reset o_rd", 32'(b0.o_rd), 0);
    chk("reset o_pc", b0.o_pc, 0);
    chk("reset o_imm", b0.o_imm_data, 0);
    chk("reset o_ready", 32'(b0.o_ready), 1);

    wb(5, 32'h1234);
    wb(1, 32'h11);
    wb(2, 32'h22);

    for (int i = 0; i < 12; i++) begin
      i_valid = 1; i_ready = 1; i_instr = vecs[i].instr; i_pc = 32'h100 + 32'(4 * i);
      i_wr = vecs[i].wr; i_wr_rd = vecs[i].wr_rd; i_write_data = vecs[i].wr_data;
      #1;
      chk($sformatf("v%0d o_ready", i), 32'(b0.o_ready), 1);
      step();
      i_valid = 0; i_wr = 0;
      chk($sformatf("v%0d o_valid", i), 32'(b0.o_valid), 1);
      chk($sformatf("v%0d rs1", i), b0.o_rs1_data, vecs[i].e_rs1);
      chk($sformatf("v%0d rs2", i), b0.o_rs2_data, vecs[i].e_rs2);
      chk($sformatf("v%0d imm", i), b0.o_imm_data, vecs[i].e_imm);
      chk($sformatf("v%0d alu", i), 32'(b0.o_alu_ctrl), 32'(vecs[i].e_alu));
      chk($sformatf("v%0d rd", i), 32'(b0.o_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d opcode", i), 32'(b0.o_opcode), 32'(vecs[i].instr[6:0]));
      chk($sformatf("v%0d pc", i), b0.o_pc, 32'h100 + 32'(4 * i));
      chk($sformatf("v%0d illegal", i), 32'(b0.o_illegal), 32'(vecs[i].e_ill));
      chk($sformatf("v%0d nobyp rs1", i), b1.o_rs1_data, vecs[i].e_rs1_nb);
      chk($sformatf("v%0d rv32e illegal", i), 32'(b2.o_illegal), 32'(vecs[i].e_ill16));
    end

    // Load-use: one bubble, then the held instruction issues.
    i_valid = 1; i_instr = 32'h00028333; i_ex_load = 1; i_ex_rd = 5; i_ready = 1;
    #1 chk("loaduse o_ready stalled", 32'(b0.o_ready), 0);
    step();
    chk("loaduse bubble", 32'(b0.o_valid), 0);
    i_ex_load = 0;
    #1 chk("loaduse o_ready after", 32'(b0.o_ready), 1);
    step();
    chk("loaduse issue valid", 32'(b0.o_valid), 1);
    chk("loaduse issue rd", 32'(b0.o_rd), 6);
    chk("loaduse issue rs1", b0.o_rs1_data, 32'h1234);
    i_instr = 32'h000012B7; i_ex_load = 1; i_ex_rd = 5;
    #1 chk("lui no stall o_ready", 32'(b0.o_ready), 1);
    step();
    chk("lui no stall valid", 32'(b0.o_valid), 1);
    chk("lui no stall rd", 32'(b0.o_rd), 5);
    idle();
    step();

    // Backpressure for three cycles, then release.
    issue(32'h00500693);
    chk("bp first valid", 32'(b0.o_valid), 1);
    i_valid = 1; i_instr = 32'h00700713; i_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d o_ready", c), 32'(b0.o_ready), 0);
      step();
      chk($sformatf("bp%0d valid", c), 32'(b0.o_valid), 1);
      chk($sformatf("bp%0d rd", c), 32'(b0.o_rd), 13);
      chk($sformatf("bp%0d imm", c), b0.o_imm_data, 32'h5);
    end
    i_ready = 1;
    #1 chk("bp release o_ready", 32'(b0.o_ready), 1);
    step();
    i_valid = 0;
    chk("bp second valid", 32'(b0.o_valid), 1);
    chk("bp second rd", 32'(b0.o_rd), 14);
    chk("bp second imm", b0.o_imm_data, 32'h7);
    step();
    chk("bp no duplicate", 32'(b0.o_valid), 0);

    // Flush with a held instruction and a new one incoming, downstream stalled.
    issue(32'h00500693);
    chk("flush pre valid", 32'(b0.o_valid), 1);
    i_valid = 1; i_instr = 32'h00700713; i_flush = 1; i_ready = 0;
    #1 chk("flush o_ready", 32'(b0.o_ready), 0);
    step();
    chk("flush valid", 32'(b0.o_valid), 0);
    idle();
    step();
    chk("flush no leak valid", 32'(b0.o_valid), 0);
    chk("flush held rd", 32'(b0.o_rd), 13);

    // Reset mid-stream together with flush and stall.
    issue(32'h00500693);
    chk("rst pre valid", 32'(b0.o_valid), 1);
    i_valid = 1; i_instr = 32'h00028333; i_flush = 1; i_ex_load = 1; i_ex_rd = 5; rst = 1;
    step();
    rst = 0; idle();
    chk("rst mid valid", 32'(b0.o_valid), 0);
    chk("rst mid rd", 32'(b0.o_rd), 0);
    chk("rst mid imm", b0.o_imm_data, 0);
    #1 chk("rst mid o_ready", 32'(b0.o_ready), 1);
    issue(32'h00028333);
    chk("rst regfile cleared", b0.o_rs1_data, 0);
    chk("rst after valid", 32'(b0.o_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the in-order RV32 pipeline, sitting between IF and EX.
- Integrates the register file, immediate generation and ALU-control decode.
- Adds an output pipeline register with valid/ready handshaking.
- Adds write-back bypass, load-use hazard stalling, flush, illegal-instruction flagging, and a configurable register count (RV32I/RV32E).

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_COUNT, 32, architectural registers (32 or 16); indices ≥ REG_COUNT are illegal
- WB_BYPASS, 1, 1 = same-cycle write-back data forwarded to operand read

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept instruction this cycle
- i_instr  in  32  instruction
- i_pc  in  XLEN  PC of i_instr
- i_flush  in  1  kill held and incoming instruction
- i_wr  in  1  WB register write enable
- i_wr_rd  in  5  WB destination index
- i_write_data  in  XLEN  WB data
- i_ex_load  in  1  instruction currently in EX is a load
- i_ex_rd  in  5  destination of instruction in EX
- o_valid  out  1  output register holds a valid decoded instruction
- i_ready  in  1  downstream accepts
- o_rs1_data, o_rs2_data  out  XLEN  operand values
- o_imm_data  out  XLEN  sign-extended immediate
- o_opcode  out  7;  o_func3  out  3;  o_alu_ctrl  out  4 (codebase ALU encoding)
- o_rs1, o_rs2, o_rd  out  5  register indices
- o_pc  out  XLEN  PC passed through
- o_illegal  out  1  unsupported opcode or out-of-range register index

## Operation
- Register file:
  - REG_COUNT × XLEN, x0 reads 0.
  - Write on posedge when i_wr && i_wr_rd != 0 && i_wr_rd < REG_COUNT.
  - All entries cleared on rst.
- Operand read:
  - Combinational from i_instr[19:15] and i_instr[24:20].
  - If WB_BYPASS and i_wr && i_wr_rd == rs && rs != 0, use i_write_data instead of the array value.
- Operand use:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by R, S and B types.
  - Unused operand data is forced to 0.
- Hazard:
  - stall = i_valid && i_ex_load && i_ex_rd != 0 && (i_ex_rd matches a *used* rs).
- Handshake:
  - advance = !o_valid || i_ready.
  - o_ready = advance && !stall && !i_flush.
- Output register load, when advance:
  - Instruction accepted (i_valid && o_ready): load decoded fields and set o_valid=1.
  - Otherwise (no input, stall or flush): o_valid=0 (bubble); data fields hold their previous values.
- Flush:
  - The next cycle o_valid=0 regardless of i_ready.
  - The incoming instruction is not accepted.
  - Flush overrides stall.
- Illegal:
  - Set if the opcode is outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM}, or if any used rs/rd ≥ REG_COUNT.
  - The instruction still flows through with o_illegal=1; its alu_ctrl is ADD.

## Timing
- Reset: o_valid=0, o_illegal=0, all data/index outputs 0, register file 0; o_ready=1 the cycle after rst deasserts.
- Latency: 1 cycle, from the accepting edge to o_valid.
- Throughput: 1 instruction/cycle while i_ready=1 and no hazard.
- Backpressure: with o_valid=1 and i_ready=0, all outputs hold stable and o_ready=0.
- Load-use: exactly one bubble per EX load, since the hazard clears when the load leaves EX. The stalled instruction is held upstream (o_ready=0) and accepted the next cycle.
- Same-cycle WB write and read of the same register:
  - WB_BYPASS=1: new value.
  - WB_BYPASS=0: old value.
- Write to x0 is always dropped; reads of x0 always return 0, including under bypass.
- rst mid-stream discards the held instruction and clears the register file in the same edge.
- rst, flush and stall asserted simultaneously: rst dominates, then flush.

## Test plan
- Reset, then write x5=0x0000_1234 via WB; issue `add x6,x5,x0` (0x00028333) → o_valid next cycle, o_rs1_data=0x1234, o_rs2_data=0, o_rd=6.
- Same-cycle WB x7=0xDEAD_BEEF with decode of `addi x8,x7,-1` → WB_BYPASS=1 gives o_rs1_data=0xDEADBEEF, o_imm_data=0xFFFF_FFFF; WB_BYPASS=0 gives 0.
- i_ex_load=1, i_ex_rd=5, decode `add x6,x5,x0` → o_ready=0 for one cycle, one bubble (o_valid=0), then the instruction is issued. Same setup with `lui x5,1` → no stall.
- o_valid=1, i_ready=0 for 3 cycles → all outputs stable, o_ready=0; then i_ready=1 → next instruction issued with no loss or duplication.
- i_flush with o_valid=1 and i_valid=1 → o_valid=0 next cycle; the input instruction does not appear at the output.
- REG_COUNT=16, decode `add x17,x1,x2` → o_illegal=1. Opcode 0x0B → o_illegal=1. A write to x0 followed by a read of x0 returns 0.
